category_score_argmax: RTL and testbench
========================================

CATEGORY_SCORE_ARGMAX -- requirements
Module: category_score_argmax

Interface
REQ-001 SHALL have parameter CATEGORIES, default 10, number of output classes (>=2).
REQ-002 SHALL have parameter BITS_PER_CATEGORY, default 800, vote bits per class per frame.
REQ-003 SHALL have parameter CHUNK, default 16, vote bits per class per beat; must divide BITS_PER_CATEGORY exactly.
REQ-004 SHALL have port clk  input  1  single clock; all state changes on posedge clk.
REQ-005 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-006 SHALL have port flush  input  1  abandon the current frame.
REQ-007 SHALL have port in_bits  input  CATEGORIES*CHUNK  beat; class c occupies bits [c*CHUNK +: CHUNK].
REQ-008 SHALL have port in_valid  input  1  beat offered.
REQ-009 SHALL have port in_ready  output  1  beat accepted when in_valid && in_ready.
REQ-010 SHALL have port out_valid  output  1  result held.
REQ-011 SHALL have port out_ready  input  1  result consumed when out_valid && out_ready.
REQ-012 SHALL have port out_index  output  IW=$clog2(CATEGORIES)  winning class.
REQ-013 SHALL have port out_score  output  SW=$clog2(BITS_PER_CATEGORY+1)  winning popcount.
REQ-014 SHALL have port out_margin  output  SW  winner score minus runner-up score.

Function
REQ-015 SHALL implement FSM states ACCUM, SCAN, HOLD; in_ready=1 only in ACCUM; out_valid=1 only in HOLD.
REQ-016 ACCUM: each accepted beat SHALL add popcount of each class slice to that class's SW-bit accumulator and increment beat counter.
REQ-017 Accumulators SHALL be SW bits wide, so the maximum score BITS_PER_CATEGORY is representable and never wraps.
REQ-018 Acceptance of beat number BITS_PER_CATEGORY/CHUNK SHALL move ACCUM->SCAN and clear the beat counter.
REQ-019 SCAN SHALL compare one class per cycle, index 0 first, for exactly CATEGORIES cycles, then move to HOLD.
REQ-020 out_valid SHALL rise exactly CATEGORIES+1 cycles after the edge that accepts the final beat.
REQ-021 Comparison SHALL be strict greater-than; on a tie the lowest index wins.
REQ-022 In HOLD, out_index/out_score/out_margin SHALL stay stable until the handshake completes.
REQ-023 On HOLD handshake, SHALL clear all accumulators and return to ACCUM; in_ready SHALL be 1 on the next cycle.
REQ-024 flush=1 in any state SHALL clear accumulators, beat counter and best/second registers and enter ACCUM next cycle.
REQ-025 flush with in_valid in the same cycle SHALL discard the beat; flush SHALL override a concurrent HOLD handshake.
REQ-026 Outputs SHALL be registered; no combinational path from in_* to out_*.

Reset
REQ-027 rst SHALL take priority over flush and all other inputs.
REQ-028 After rst: state ACCUM, accumulators and counters 0, in_ready=1, out_valid=0, out_index=0, out_score=0, out_margin=0.
REQ-029 rst asserted mid-frame or mid-SCAN SHALL discard all partial results.

Configuration
REQ-030 With SCORE_MARGIN_EN defined, SCAN SHALL also track the runner-up score, and out_margin SHALL equal best minus runner-up (0 on a tie).
REQ-031 Without SCORE_MARGIN_EN, no runner-up register SHALL exist and out_margin SHALL be constant 0.

Structure
REQ-032 A shared package SHALL hold the FSM state enum and helper width functions (index and score width).
REQ-033 A sub-module chunk_popcount SHALL compute one CHUNK-bit popcount and be instantiated once per class.

Verification
All cases use defaults (10 classes, 800 bits, 16 per beat, 50 beats).
REQ-034 Class 3 slice all ones for 50 beats, other slices zero -> out_index=3, out_score=800, out_margin=800 (0 without the macro).
REQ-035 Classes 2 and 7 each at 0x00FF every beat (score 400) -> out_index=2, out_score=400, out_margin=0.
REQ-036 All-zero frame -> out_index=0, out_score=0, out_margin=0, out_valid 11 cycles after the last beat.
REQ-037 out_ready held low 20 cycles in HOLD -> outputs stable, in_ready=0 throughout; release -> in_ready=1 the next cycle.
REQ-038 Flush after 25 beats, then a full frame with class 9 all ones -> out_index=9, out_score=800 (no residue from the flushed beats).
REQ-039 rst pulse during SCAN -> out_valid=0 and in_ready=1 on the following cycle; the next full frame scores correctly.

Source files
------------

// File: rtl/category_score_argmax_pkg.sv
// category_score_argmax_pkg: FSM states and width helpers
// shared by category_score_argmax and its bench-facing ports.
package category_score_argmax_pkg;

  typedef enum logic [1:0] {
    ACCUM,
    SCAN,
    HOLD
  } state_t;

  function automatic int idx_w(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

  function automatic int score_w(input int b);
    return $clog2(b + 1);
  endfunction

endpackage

// File: rtl/category_score_argmax_popcount.sv
// chunk_popcount: number of set bits in one W-bit slice.
// Ports: bits (W) in, cnt ($clog2(W+1)) out; purely combinational.
module chunk_popcount #(
  parameter int W  = 16,
  parameter int PW = $clog2(W + 1)
) (
  input  logic [W-1:0]  bits,
  output logic [PW-1:0] cnt
);

  always_comb begin
    cnt = '0;
    for (int i = 0; i < W; i++) begin
      cnt = cnt + PW'(bits[i]);
    end
  end

endmodule

// File: rtl/category_score_argmax.sv
// category_score_argmax: accumulates per-class vote popcounts over a
// frame of BITS_PER_CATEGORY/CHUNK beats, then scans for the winner.
// Ports: clk, rst (sync, high), flush; in_bits/in_valid/in_ready beat
// stream; out_valid/out_ready result handshake with out_index,
// out_score, out_margin. Define SCORE_MARGIN_EN for runner-up margin.
module category_score_argmax
  import category_score_argmax_pkg::*;
#(
  parameter int CATEGORIES        = 10,
  parameter int BITS_PER_CATEGORY = 800,
  parameter int CHUNK             = 16
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic                                  flush,
  input  logic [CATEGORIES*CHUNK-1:0]           in_bits,
  input  logic                                  in_valid,
  output logic                                  in_ready,
  output logic                                  out_valid,
  input  logic                                  out_ready,
  output logic [idx_w(CATEGORIES)-1:0]          out_index,
  output logic [score_w(BITS_PER_CATEGORY)-1:0] out_score,
  output logic [score_w(BITS_PER_CATEGORY)-1:0] out_margin
);

  localparam int IW    = idx_w(CATEGORIES);
  localparam int SW    = score_w(BITS_PER_CATEGORY);
  localparam int PW    = $clog2(CHUNK + 1);
  localparam int BEATS = BITS_PER_CATEGORY / CHUNK;
  localparam int BW    = $clog2(BEATS + 1);

  state_t          state;
  state_t          state_n;
  logic [BW-1:0]   beat;
  logic [IW-1:0]   scan_i;
  logic [SW-1:0]   acc [CATEGORIES];
  logic [PW-1:0]   pc  [CATEGORIES];
  logic [SW-1:0]   cand;
  logic [SW-1:0]   best_sc;
  logic [IW-1:0]   best_idx;
  logic            take;
  logic            give;
  logic            last_beat;
  logic            scan_done;

  for (genvar c = 0; c < CATEGORIES; c++) begin : g_pc
    chunk_popcount #(
      .W  (CHUNK),
      .PW (PW)
    ) u_pc (
      .bits (in_bits[c*CHUNK +: CHUNK]),
      .cnt  (pc[c])
    );
  end

  assign in_ready  = (state == ACCUM);
  assign take      = in_valid && (state == ACCUM);
  assign give      = (state == HOLD) && out_valid && out_ready;
  assign last_beat = (beat == BW'(BEATS - 1));
  assign scan_done = (scan_i == IW'(CATEGORIES - 1));
  assign cand      = acc[scan_i];

  always_comb begin
    state_n = state;
    unique case (state)
      ACCUM:   if (take && last_beat) state_n = SCAN;
      SCAN:    if (scan_done) state_n = HOLD;
      HOLD:    if (give) state_n = ACCUM;
      default: state_n = ACCUM;
    endcase
    if (flush) state_n = ACCUM;
  end

  always_ff @(posedge clk) begin
    if (rst) state <= ACCUM;
    else     state <= state_n;
  end

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      beat      <= '0;
      scan_i    <= '0;
      best_sc   <= '0;
      best_idx  <= '0;
      out_valid <= 1'b0;
      out_index <= '0;
      out_score <= '0;
      for (int c = 0; c < CATEGORIES; c++) acc[c] <= '0;
    end else begin
      if (take) begin
        for (int c = 0; c < CATEGORIES; c++)
          acc[c] <= acc[c] + SW'(pc[c]);
        beat <= last_beat ? '0 : beat + BW'(1);
      end
      if (state == SCAN) begin
        scan_i <= scan_done ? '0 : scan_i + IW'(1);
        // class 0 seeds the search; strict > keeps lowest index on ties
        if (scan_i == '0) begin
          best_sc  <= cand;
          best_idx <= '0;
        end else if (cand > best_sc) begin
          best_sc  <= cand;
          best_idx <= scan_i;
        end
      end
      // first HOLD cycle latches the result into the output registers
      if ((state == HOLD) && !out_valid) begin
        out_valid <= 1'b1;
        out_index <= best_idx;
        out_score <= best_sc;
      end
      if (give) begin
        out_valid <= 1'b0;
        for (int c = 0; c < CATEGORIES; c++) acc[c] <= '0;
      end
    end
  end

`ifdef SCORE_MARGIN_EN
  logic [SW-1:0] second;

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      second     <= '0;
      out_margin <= '0;
    end else begin
      if (state == SCAN) begin
        if (scan_i == '0)        second <= '0;
        else if (cand > best_sc) second <= best_sc;
        else if (cand > second)  second <= cand;
      end
      if ((state == HOLD) && !out_valid)
        out_margin <= best_sc - second;
    end
  end
`else
  assign out_margin = '0;
`endif

endmodule

// File: tb/tb_category_score_argmax.sv
// tb_category_score_argmax: random and directed frames checked
// against a per-frame score model; covers flush, rst and HOLD stall.
module tb_category_score_argmax;

  localparam int C = 10;
  localparam int B = 800;
  localparam int K = 16;
  localparam int N = B / K;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           flush = 1'b0;
  logic           in_valid = 1'b0;
  logic           out_ready = 1'b0;
  logic [C*K-1:0] in_bits = '0;
  logic           in_ready;
  logic           out_valid;
  logic [3:0]     out_index;
  logic [9:0]     out_score;
  logic [9:0]     out_margin;

  int total = 0;
  int bad = 0;

  logic [C*K-1:0] frame [N];

  always #5 clk = ~clk;

  category_score_argmax #(
    .CATEGORIES        (C),
    .BITS_PER_CATEGORY (B),
    .CHUNK             (K)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .flush      (flush),
    .in_bits    (in_bits),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_index  (out_index),
    .out_score  (out_score),
    .out_margin (out_margin)
  );

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model(output int ei, output int es, output int em);
    int sc [C];
    int run;
    for (int c = 0; c < C; c++) sc[c] = 0;
    for (int b = 0; b < N; b++)
      for (int c = 0; c < C; c++)
        sc[c] += $countones(frame[b][c*K +: K]);
    ei = 0;
    for (int c = 1; c < C; c++)
      if (sc[c] > sc[ei]) ei = c;
    run = -1;
    for (int c = 0; c < C; c++)
      if (c != ei && sc[c] > run) run = sc[c];
    es = sc[ei];
`ifdef SCORE_MARGIN_EN
    em = es - run;
`else
    em = 0;
`endif
  endtask

  task automatic clear_frame();
    for (int b = 0; b < N; b++) frame[b] = '0;
  endtask

  task automatic fill_rand(input bit sparse);
    logic [31:0] r;
    logic [15:0] w;
    for (int b = 0; b < N; b++)
      for (int c = 0; c < C; c++) begin
        r = $urandom;
        w = r[15:0];
        if (sparse) w = w & r[31:16];
        frame[b][c*K +: K] = w;
      end
  endtask

  task automatic drive_beats(input int n);
    for (int b = 0; b < n; b++) begin
      in_bits  = frame[b];
      in_valid = 1'b1;
      tick();
    end
    in_valid = 1'b0;
    in_bits  = '0;
  endtask

  task automatic expect_result(input string tag);
    int ei, es, em;
    int cnt;
    model(ei, es, em);
    cnt = 0;
    while (!out_valid && cnt < 60) begin
      tick();
      cnt++;
    end
    chk({tag, "_latency"}, cnt, C + 1);
    chk({tag, "_index"}, out_index, ei);
    chk({tag, "_score"}, out_score, es);
    chk({tag, "_margin"}, out_margin, em);
  endtask

  task automatic consume();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("consume_in_ready", in_ready, 1);
    chk("consume_out_valid", out_valid, 0);
  endtask

  initial begin
    logic [25:0] held;
    logic [31:0] r;

    tick();
    tick();
    rst = 1'b0;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_index", out_index, 0);
    chk("rst_score", out_score, 0);
    chk("rst_margin", out_margin, 0);

    clear_frame();
    for (int b = 0; b < N; b++) frame[b][3*K +: K] = '1;
    drive_beats(N);
    expect_result("one_hot3");
    consume();

    clear_frame();
    for (int b = 0; b < N; b++) begin
      frame[b][2*K +: K] = 16'h00FF;
      frame[b][7*K +: K] = 16'h00FF;
    end
    drive_beats(N);
    expect_result("tie27");
    consume();

    clear_frame();
    drive_beats(N);
    expect_result("zero");
    consume();

    for (int t = 0; t < 4; t++) begin
      fill_rand(t[0]);
      drive_beats(N);
      expect_result("rand");
      consume();
    end

    fill_rand(1'b0);
    drive_beats(N);
    expect_result("stall");
    held = {out_index, out_score, out_margin, out_valid, in_ready};
    for (int i = 0; i < 20; i++) begin
      tick();
      chk("stall_stable",
          {out_index, out_score, out_margin, out_valid, in_ready}, held);
    end
    consume();

    fill_rand(1'b0);
    drive_beats(25);
    r = $urandom;
    in_bits  = {C{r[15:0]}};
    in_valid = 1'b1;
    flush    = 1'b1;
    tick();
    flush    = 1'b0;
    in_valid = 1'b0;
    chk("flush_in_ready", in_ready, 1);
    chk("flush_out_valid", out_valid, 0);
    clear_frame();
    for (int b = 0; b < N; b++) frame[b][9*K +: K] = '1;
    drive_beats(N);
    expect_result("after_flush9");
    chk("after_flush9_const", out_score, 800);
    consume();

    fill_rand(1'b0);
    drive_beats(N);
    tick();
    tick();
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("scan_rst_out_valid", out_valid, 0);
    chk("scan_rst_in_ready", in_ready, 1);
    for (int i = 0; i < 15; i++) tick();
    chk("scan_rst_no_result", out_valid, 0);
    fill_rand(1'b1);
    drive_beats(N);
    expect_result("after_rst");
    consume();

    fill_rand(1'b0);
    drive_beats(N);
    expect_result("hold_flush");
    flush     = 1'b1;
    out_ready = 1'b1;
    tick();
    flush     = 1'b0;
    out_ready = 1'b0;
    chk("hold_flush_out_valid", out_valid, 0);
    chk("hold_flush_in_ready", in_ready, 1);
    fill_rand(1'b0);
    drive_beats(N);
    expect_result("post_hold_flush");
    consume();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
